// File: rtl/adder_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_port_scheduler_if
// Purpose  : Request/response bundle for the shared 4-bit adder scheduler.
//            The master side presents operands and absorbs results.
//            The slave side (the scheduler) grants requests and returns sums.
// Signals  : req_valid/req_ready   per-port request handshake (bit = port)
//            req_a0/b0/cin0        port 0 operands
//            req_a1/b1/cin1        port 1 operands
//            rsp_valid/rsp_ready   result handshake
//            rsp_id/sum/cout/wide  result payload
// Revision : 1.0  initial release
// ============================================================================
interface adder_port_scheduler_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0;
  logic [7:0] req_b0;
  logic       req_cin0;
  logic [7:0] req_a1;
  logic [7:0] req_b1;
  logic       req_cin1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_sum;
  logic       rsp_cout;
  logic       rsp_wide;

  modport master (
    output req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_wide
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_wide
  );
endinterface
`default_nettype wire

// File: rtl/adder_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adder_port_scheduler
// Purpose  : Time-multiplexes one 4-bit adder slice between two requesters.
//            Nibble-sized operands take one low pass; wider operands take a
//            low pass then a high pass with the carry chained between them.
//            A round-robin arbiter picks the requester; the result is held
//            in DONE until the downstream accepts it.
// Ports    : clk   clock, rising edge
//            rst   asynchronous active-high reset
//            en    gates acceptance of new requests (in-flight work finishes)
//            busy  high whenever the FSM is not IDLE
//            bus   request/response bundle (slave modport)
// Revision : 1.0  initial release
// ============================================================================
module adder_port_scheduler (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              en,
  output logic                   busy,
  adder_port_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Captured request
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cin_q;
  logic       id_q;
  logic       small_q;
  logic       last_served;

  // Low-pass partial result, consumed by the high pass
  logic [3:0] lo_q;
  logic       c4_q;

  // Held response payload
  logic [7:0] sum_q;
  logic       cout_q;
  logic       wide_q;

  logic       grant;
  logic [1:0] ready;
  logic       accept;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic       sel_cin;
  logic [4:0] low_add;
  logic [4:0] high_add;

  // Arbitration: a lone requester wins; on contention the port that was
  // not served last wins.
  always_comb begin
    grant = (bus.req_valid == 2'b11) ? ~last_served : bus.req_valid[1];
    ready = 2'b00;
    // rst gating keeps req_ready low for the whole reset pulse, not just
    // after the state register has been forced to IDLE.
    if ((state == IDLE) && en && !rst && (bus.req_valid != 2'b00)) begin
      ready = grant ? 2'b10 : 2'b01;
    end
    accept  = |(bus.req_valid & ready);
    sel_a   = grant ? bus.req_a1   : bus.req_a0;
    sel_b   = grant ? bus.req_b1   : bus.req_b0;
    sel_cin = grant ? bus.req_cin1 : bus.req_cin0;
  end

  // The single shared slice, viewed once per pass
  always_comb begin
    low_add  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, cin_q};
    high_add = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0000, c4_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_next = LOW;
      LOW:     state_next = small_q ? DONE : HIGH;
      HIGH:    state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      small_q     <= 1'b0;
      last_served <= 1'b1;
      lo_q        <= 4'h0;
      c4_q        <= 1'b0;
      sum_q       <= 8'h00;
      cout_q      <= 1'b0;
      wide_q      <= 1'b0;
    end else begin
      if (accept) begin
        a_q         <= sel_a;
        b_q         <= sel_b;
        cin_q       <= sel_cin;
        id_q        <= grant;
        last_served <= grant;
        small_q     <= (sel_a[7:4] == 4'h0) && (sel_b[7:4] == 4'h0);
      end
      if (state == LOW) begin
        lo_q <= low_add[3:0];
        c4_q <= low_add[4];
        if (small_q) begin
          sum_q  <= {4'h0, low_add[3:0]};
          cout_q <= low_add[4];
          wide_q <= 1'b0;
        end
      end
      if (state == HIGH) begin
        sum_q  <= {high_add[3:0], lo_q};
        cout_q <= high_add[4];
        wide_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_wide  = wide_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_port_scheduler
// Purpose  : Self-checking bench for adder_port_scheduler. A cycle-level
//            transaction model (grant rule, full 8-bit arithmetic, latency
//            countdown) is compared against the DUT on every falling edge;
//            directed operations additionally pin literal results.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_port_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy;

  always #5 clk = ~clk;

  adder_port_scheduler_if bus_if ();

  adder_port_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .busy (busy),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction model: 0 = idle, 1 = computing, 2 = result presented
  // ------------------------------------------------------------------
  int         m_state = 0;
  int         m_left  = 0;
  logic       m_last  = 1'b1;
  logic [7:0] e_sum;
  logic       e_cout;
  logic       e_wide;
  logic       e_id;
  logic [1:0] e_ready;
  logic       m_g;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_c;
  logic [8:0] m_full;
  logic [4:0] m_nib;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst busy",      busy,             0);
      chk("rst req_ready", bus_if.req_ready, 0);
      chk("rst rsp_valid", bus_if.rsp_valid, 0);
      chk("rst rsp_sum",   bus_if.rsp_sum,   0);
      chk("rst rsp_cout",  bus_if.rsp_cout,  0);
      chk("rst rsp_wide",  bus_if.rsp_wide,  0);
      chk("rst rsp_id",    bus_if.rsp_id,    0);
      m_state = 0;
      m_last  = 1'b1;
    end else begin
      e_ready = 2'b00;
      m_g     = 1'b0;
      if (m_state == 0 && en && bus_if.req_valid != 2'b00) begin
        if (bus_if.req_valid == 2'b11) m_g = ~m_last;
        else                           m_g = bus_if.req_valid[1];
        e_ready = m_g ? 2'b10 : 2'b01;
      end
      chk("model req_ready", bus_if.req_ready, e_ready);
      chk("model busy",      busy,             m_state != 0);
      chk("model rsp_valid", bus_if.rsp_valid, m_state == 2);
      if (m_state == 2) begin
        chk("model rsp_sum",  bus_if.rsp_sum,  e_sum);
        chk("model rsp_cout", bus_if.rsp_cout, e_cout);
        chk("model rsp_wide", bus_if.rsp_wide, e_wide);
        chk("model rsp_id",   bus_if.rsp_id,   e_id);
      end
      // Advance across the coming rising edge
      case (m_state)
        0: if (e_ready != 2'b00) begin
          m_a = m_g ? bus_if.req_a1   : bus_if.req_a0;
          m_b = m_g ? bus_if.req_b1   : bus_if.req_b0;
          m_c = m_g ? bus_if.req_cin1 : bus_if.req_cin0;
          if (m_a <= 8'h0F && m_b <= 8'h0F) begin
            m_nib  = {1'b0, m_a[3:0]} + {1'b0, m_b[3:0]} + {4'b0, m_c};
            e_sum  = {4'h0, m_nib[3:0]};
            e_cout = m_nib[4];
            e_wide = 1'b0;
            m_left = 1;
          end else begin
            m_full = {1'b0, m_a} + {1'b0, m_b} + {8'b0, m_c};
            e_sum  = m_full[7:0];
            e_cout = m_full[8];
            e_wide = 1'b1;
            m_left = 2;
          end
          e_id    = m_g;
          m_last  = m_g;
          m_state = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        2: if (bus_if.rsp_ready) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [7:0] a, input logic [7:0] b, input logic c);
    if (p == 0) begin
      bus_if.req_a0 = a; bus_if.req_b0 = b; bus_if.req_cin0 = c;
      bus_if.req_valid[0] = 1'b1;
    end else begin
      bus_if.req_a1 = a; bus_if.req_b1 = b; bus_if.req_cin1 = c;
      bus_if.req_valid[1] = 1'b1;
    end
  endtask

  // Waits for the port's grant, lets it be accepted at the next edge, then
  // scrambles that port's operands (must not matter any more).
  task automatic accept_port(input string name, input int p);
    int got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.req_ready[p]) begin got = 1; break; end
    end
    chk({name, " granted"}, got, 1);
    tick();
    bus_if.req_valid[p] = 1'b0;
    if (p == 0) begin
      bus_if.req_a0 = ~bus_if.req_a0; bus_if.req_b0 = ~bus_if.req_b0; bus_if.req_cin0 = ~bus_if.req_cin0;
    end else begin
      bus_if.req_a1 = ~bus_if.req_a1; bus_if.req_b1 = ~bus_if.req_b1; bus_if.req_cin1 = ~bus_if.req_cin1;
    end
  endtask

  // Edges after the accept edge until rsp_valid is seen (0 = timeout)
  task automatic wait_rsp(output int k);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus_if.rsp_valid) begin k = i; break; end
    end
  endtask

  task automatic run_op(input string name, input int p, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec, input logic ew,
                        input int lat);
    int k;
    drive(p, a, b, c);
    accept_port(name, p);
    wait_rsp(k);
    chk({name, " latency"}, k, lat);
    chk({name, " sum"},  bus_if.rsp_sum,  es);
    chk({name, " cout"}, bus_if.rsp_cout, ec);
    chk({name, " wide"}, bus_if.rsp_wide, ew);
    chk({name, " id"},   bus_if.rsp_id,   p);
    tick();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      tick();
    end
    chk({name, " idle"}, busy, 0);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  initial begin
    int gseq[$];
    int k;
    rst = 1'b1;
    en  = 1'b1;
    bus_if.req_valid = 2'b00;
    bus_if.rsp_ready = 1'b1;
    bus_if.req_a0 = 8'h00; bus_if.req_b0 = 8'h00; bus_if.req_cin0 = 1'b0;
    bus_if.req_a1 = 8'h00; bus_if.req_b1 = 8'h00; bus_if.req_cin1 = 1'b0;
    #2;
    bus_if.req_valid = 2'b01;
    #1;
    chk("req_ready held low in reset", bus_if.req_ready, 2'b00);
    bus_if.req_valid = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single-pass and two-pass operations with literal results
    run_op("small 07+08+1", 0, 8'h07, 8'h08, 1'b1, 8'h00, 1'b1, 1'b0, 1);
    run_op("wide F0+20+0",  1, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b1, 2);
    run_op("chain 0F+11+1", 0, 8'h0F, 8'h11, 1'b1, 8'h21, 1'b0, 1'b1, 2);
    run_op("small 0F+0F+1", 1, 8'h0F, 8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0, 1);

    // Contention: last served is port 1, so grants go 0,1,0,1
    drive(0, 8'h33, 8'h44, 1'b0);
    drive(1, 8'h05, 8'h06, 1'b1);
    for (int i = 0; i < 60 && gseq.size() < 4; i++) begin
      @(negedge clk);
      if (bus_if.req_ready != 2'b00) gseq.push_back(bus_if.req_ready == 2'b10 ? 1 : 0);
    end
    tick();
    bus_if.req_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("contention grant %0d", j), (j < gseq.size()) ? gseq[j] : 99, j % 2);
    end
    wait_idle("after contention");

    // Backpressure with a pending request, then en gating
    bus_if.rsp_ready = 1'b0;
    drive(0, 8'h12, 8'h34, 1'b0);
    accept_port("bp op", 0);
    drive(1, 8'h09, 8'h03, 1'b0);
    wait_rsp(k);
    chk("bp latency", k, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp rsp_valid held", bus_if.rsp_valid, 1);
      chk("bp rsp_sum held",   bus_if.rsp_sum,   8'h46);
      chk("bp rsp_wide held",  bus_if.rsp_wide,  1);
      chk("bp req_ready low",  bus_if.req_ready, 2'b00);
    end
    en = 1'b0;
    bus_if.rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en low busy",      busy,             0);
      chk("en low req_ready", bus_if.req_ready, 2'b00);
    end
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("en high grants pending port 1", bus_if.req_ready, 2'b10);
    tick();
    bus_if.req_valid[1] = 1'b0;
    wait_rsp(k);
    chk("pending latency", k, 1);
    chk("pending sum", bus_if.rsp_sum, 8'h0C);
    chk("pending id",  bus_if.rsp_id,  1);
    tick();
    wait_idle("after backpressure");

    // Reset in the HIGH pass aborts the operation
    drive(0, 8'hA0, 8'h0B, 1'b1);
    accept_port("abort op", 0);
    tick();
    chk("abort busy before rst", busy, 1);
    drive(1, 8'hFF, 8'h01, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort busy",      busy,             0);
    chk("abort rsp_valid", bus_if.rsp_valid, 0);
    chk("abort req_ready", bus_if.req_ready, 2'b00);
    chk("abort rsp_sum",   bus_if.rsp_sum,   8'h00);
    repeat (2) tick();
    rst = 1'b0;
    run_op("post-reset port 1", 1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 2);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
